// File: rtl/cpu_seq_ctrl_if.sv
// Handshake bundle between the CPU sequencer and the ROM / decoder / ALU / UART side.
// The master modport is the sequencer; the slave modport is the datapath environment.
interface cpu_seq_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic             fetch_req;
   logic             fetch_ack;
   logic             dec_en;
   logic             ex_en;
   logic             ex_w_req;
   logic             ex_ack;
   logic             w_busy;
   logic             w_req;
   logic             irr;
   logic             intr_en;
   logic             intr_take;
   logic             wb_en;
   logic             ack;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;
   logic             fault;

   modport master (
      input  run, fetch_ack, ex_w_req, ex_ack, w_busy, irr, intr_en,
      output fetch_req, dec_en, ex_en, w_req, intr_take, wb_en, ack, state, retired, fault
   );

   modport slave (
      output run, fetch_ack, ex_w_req, ex_ack, w_busy, irr, intr_en,
      input  fetch_req, dec_en, ex_en, w_req, intr_take, wb_en, ack, state, retired, fault
   );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB with UART-TX serialisation,
// interrupt entry at instruction boundaries, retire counting and a sticky fetch-timeout fault.
module cpu_seq_ctrl #(
   parameter int FETCH_TO = 16,
   parameter int CNT_W    = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   cpu_seq_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      TXWAIT = 3'd4,
      WB     = 3'd5,
      INTR   = 3'd6,
      FAULT  = 3'd7
   } state_t;

   localparam int             TO_W    = (FETCH_TO > 1) ? $clog2(FETCH_TO + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (FETCH_TO > 0) ? TO_W'(FETCH_TO - 1) : '0;

   state_t           state_q;
   state_t           nxt;
   logic [TO_W-1:0]  to_cnt;
   logic             ack_l;
   logic [CNT_W-1:0] retired_q;
   logic             fault_q;
   logic             fetch_req_q;
   logic             dec_en_q;
   logic             ex_en_q;
   logic             intr_take_q;
   logic             wb_en_q;
   logic             ack_q;

   // An INTR can only be reached from IDLE or WB, and both are preceded by a retire
   // (or reset), so the "no back-to-back interrupt" rule needs no extra flag here.
   function automatic state_t boundary(input logic r, input logic i, input logic e);
      if (!r)
         return IDLE;
      else if (i && e)
         return INTR;
      else
         return FETCH;
   endfunction

   always_comb begin
      nxt = state_q;
      unique case (state_q)
         IDLE:   nxt = boundary(bus.run, bus.irr, bus.intr_en);
         FETCH: begin
            if (bus.fetch_ack)
               nxt = DECODE;
            else if (FETCH_TO != 0 && to_cnt == TO_LAST)
               nxt = FAULT;
         end
         DECODE: nxt = EXEC;
         EXEC:   nxt = bus.ex_w_req ? TXWAIT : WB;
         TXWAIT: if (!bus.w_busy) nxt = WB;
         WB:     nxt = boundary(bus.run, bus.irr, bus.intr_en);
         INTR:   nxt = FETCH;
         FAULT:  nxt = FAULT;
      endcase
   end

   // Strobes are registered from the next state, so each one is a flop tracking the
   // state register with no path from inputs to outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         to_cnt      <= '0;
         ack_l       <= 1'b0;
         retired_q   <= '0;
         fault_q     <= 1'b0;
         fetch_req_q <= 1'b0;
         dec_en_q    <= 1'b0;
         ex_en_q     <= 1'b0;
         intr_take_q <= 1'b0;
         wb_en_q     <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values.
         state_q <= nxt;
         to_cnt  <= (state_q == FETCH && nxt == FETCH) ? to_cnt + TO_W'(1) : '0;
         if (state_q == EXEC)
            ack_l <= bus.ex_ack;
         if (state_q == WB)
            retired_q <= retired_q + CNT_W'(1);
         if (nxt == FAULT)
            fault_q <= 1'b1;
         fetch_req_q <= (nxt == FETCH);
         dec_en_q    <= (nxt == DECODE);
         ex_en_q     <= (nxt == EXEC);
         intr_take_q <= (nxt == INTR);
         wb_en_q     <= (nxt == WB);
         ack_q       <= (nxt == WB) && ((state_q == EXEC) ? bus.ex_ack : ack_l);
      end
   end

   // NOTE: w_req is the one deliberately combinational strobe: it must fire in the
   // same cycle the UART reports not-busy, and never while busy.
   assign bus.w_req     = (state_q == TXWAIT) && !bus.w_busy;
   assign bus.fetch_req = fetch_req_q;
   assign bus.dec_en    = dec_en_q;
   assign bus.ex_en     = ex_en_q;
   assign bus.intr_take = intr_take_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.ack       = ack_q;
   assign bus.state     = state_q;
   assign bus.retired   = retired_q;
   assign bus.fault     = fault_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cpu_seq_ctrl;
   localparam int FETCH_TO = 16;
   localparam int CNT_W    = 32;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
   localparam int S_TXWAIT = 4, S_WB = 5, S_INTR = 6, S_FAULT = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_on = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   cpu_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

   cpu_seq_ctrl #(.FETCH_TO(FETCH_TO), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: which phase the current instruction is in, counted in cycles.
   int               m_st;
   int               m_fcyc;   // 1-based index of the current FETCH cycle
   bit               m_ackl;
   bit               m_took;   // interrupt entered, no instruction retired since
   bit               m_fault;
   logic [CNT_W-1:0] m_retired;

   function automatic int next_boundary(input bit took);
      if (!bus.run) return S_IDLE;
      if (bus.irr && bus.intr_en && !took) return S_INTR;
      return S_FETCH;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= S_IDLE; m_fcyc <= 1; m_ackl <= 1'b0;
         m_took <= 1'b0; m_fault <= 1'b0; m_retired <= '0;
      end else begin
         m_fcyc <= 1;
         case (m_st)
            S_IDLE:   m_st <= next_boundary(m_took);
            S_FETCH: begin
               if (bus.fetch_ack) m_st <= S_DECODE;
               else if (FETCH_TO != 0 && m_fcyc == FETCH_TO) begin
                  m_st <= S_FAULT; m_fault <= 1'b1;
               end else m_fcyc <= m_fcyc + 1;
            end
            S_DECODE: m_st <= S_EXEC;
            S_EXEC: begin
               m_ackl <= bus.ex_ack;
               m_st   <= bus.ex_w_req ? S_TXWAIT : S_WB;
            end
            S_TXWAIT: if (!bus.w_busy) m_st <= S_WB;
            S_WB: begin
               m_retired <= m_retired + 1;
               m_took    <= 1'b0;
               m_st      <= next_boundary(1'b0);
            end
            S_INTR: begin m_took <= 1'b1; m_st <= S_FETCH; end
            default: m_st <= S_FAULT;
         endcase
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         logic [10:0] exp_v, act_v;
         exp_v = {m_fault, (m_st == S_WB) && m_ackl, m_st == S_WB, m_st == S_INTR,
                  (m_st == S_TXWAIT) && !bus.w_busy, m_st == S_EXEC, m_st == S_DECODE,
                  m_st == S_FETCH, 3'(m_st)};
         act_v = {bus.fault, bus.ack, bus.wb_en, bus.intr_take, bus.w_req, bus.ex_en,
                  bus.dec_en, bus.fetch_req, bus.state};
         check("outputs{fault,ack,wb,intr,wreq,ex,dec,fetch,state}", act_v, exp_v);
         check("retired", bus.retired, m_retired);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_for(input int target, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
         step();
         if (m_st == target) hit = 1'b1;
      end
      check({"reach ", name}, hit, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("reset state", bus.state, 0);
      check("reset fault", bus.fault, 0);
      check("reset retired", bus.retired, 0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.run = 0; bus.fetch_ack = 0; bus.ex_w_req = 0; bus.ex_ack = 0;
      bus.w_busy = 0; bus.irr = 0; bus.intr_en = 0;
      repeat (3) @(posedge clk);
      #2;
      chk_on = 1'b1;
      check("reset state", bus.state, 0);
      check("reset strobes", {bus.fetch_req, bus.wb_en, bus.w_req, bus.intr_take}, 0);
      rst_n = 1'b1;

      // Zero-wait fetch, no TX: 4 cycles per instruction.
      step();
      bus.run = 1; bus.fetch_ack = 1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("fetch_req cyc%0d", k), bus.fetch_req, (k % 4) == 1);
         check($sformatf("wb_en cyc%0d", k), bus.wb_en, (k % 4) == 0);
      end
      step();
      check("retired after 3", bus.retired, 3);

      // TX write held off by w_busy for 5 TXWAIT cycles.
      bus.ex_w_req = 1; bus.w_busy = 1;
      wait_for(S_EXEC, "EXEC tx");
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("txwait hold %0d", i), bus.state, S_TXWAIT);
         check($sformatf("no w_req busy %0d", i), bus.w_req, 0);
      end
      step();
      bus.w_busy = 0; bus.ex_w_req = 0;
      #1;
      check("w_req pulse", bus.w_req, 1);
      step();
      check("wb after tx", bus.wb_en, 1);
      check("w_req single", bus.w_req, 0);

      // Interrupt raised during DECODE is taken after the commit, once per retire.
      wait_for(S_DECODE, "DECODE irq");
      bus.irr = 1; bus.intr_en = 1;
      wait_for(S_WB, "WB irq");
      check("commit before intr", bus.wb_en, 1);
      step();
      check("intr_take", bus.intr_take, 1);
      step();
      check("fetch after intr", bus.fetch_req, 1);
      begin
         int n_intr = 0;
         bit got_wb = 1'b0;
         for (int i = 0; i < 40 && !got_wb; i++) begin
            step();
            if (bus.intr_take) n_intr++;
            if (bus.wb_en) got_wb = 1'b1;
         end
         check("no intr before retire", n_intr, 0);
         check("retire after intr", got_wb, 1);
      end
      step();
      check("second intr_take", bus.intr_take, 1);
      bus.irr = 0;

      // Fetch timeout: ack on the limit cycle wins, then a real timeout faults.
      bus.run = 0;
      wait_for(S_IDLE, "IDLE to");
      bus.fetch_ack = 0; bus.run = 1;
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("fetch wait %0d", k), bus.state, S_FETCH);
      end
      bus.fetch_ack = 1;
      step();
      check("ack at limit -> DECODE", bus.state, S_DECODE);
      check("no fault at limit", bus.fault, 0);
      bus.fetch_ack = 0;
      wait_for(S_FETCH, "FETCH to");
      for (int k = 2; k <= 16; k++) step();
      step();
      check("timeout -> FAULT", bus.state, S_FAULT);
      check("fault set", bus.fault, 1);
      bus.fetch_ack = 1;
      repeat (10) step();
      check("fault sticky", bus.fault, 1);
      check("fault no fetch", bus.fetch_req, 0);

      // ack with wb_en; run dropped in EXEC still completes.
      do_reset();
      bus.ex_ack = 1; bus.ex_w_req = 0; bus.w_busy = 0;
      wait_for(S_EXEC, "EXEC ack");
      bus.run = 0;
      step();
      check("wb with ack", {bus.wb_en, bus.ack}, 2'b11);
      step();
      check("idle after run drop", bus.state, S_IDLE);
      check("no fetch idle", {bus.fetch_req, bus.ack}, 0);
      bus.ex_ack = 0;

      // Reset pulse during TXWAIT aborts with no commit.
      do_reset();
      bus.run = 1; bus.ex_w_req = 1; bus.w_busy = 1;
      wait_for(S_TXWAIT, "TXWAIT rst");
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check("async reset state", bus.state, S_IDLE);
      check("reset no strobes", {bus.w_req, bus.wb_en}, 0);
      check("reset retired 0", bus.retired, 0);
      step();
      rst_n = 1'b1; bus.run = 0; bus.ex_w_req = 0; bus.w_busy = 0;
      repeat (3) step();
      check("retired stays 0", bus.retired, 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_n         = ($urandom_range(0, 599) != 0);
         bus.run       = ($urandom_range(0, 9) != 0);
         bus.fetch_ack = $urandom_range(0, 1);
         bus.ex_w_req  = ($urandom_range(0, 9) < 3);
         bus.ex_ack    = $urandom_range(0, 1);
         bus.w_busy    = $urandom_range(0, 1);
         bus.irr       = ($urandom_range(0, 4) == 0);
         bus.intr_en   = ($urandom_range(0, 9) < 7);
      end
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
